// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: icodes, ALU functions,
// condition codes, the RNONE register ID and condition-code bit positions.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_e;

  localparam logic [3:0] C_UNC = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] RNONE = 4'hF;

  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  // Branch/cmov condition from a {ZF,SF,OF} snapshot; unknown codes are false.
  function automatic logic cond_eval(input logic [2:0] cc, input logic [3:0] ifun);
    logic lt;
    lt = cc[CC_SF] ^ cc[CC_OF];
    case (ifun)
      C_UNC:   cond_eval = 1'b1;
      C_LE:    cond_eval = lt | cc[CC_ZF];
      C_L:     cond_eval = lt;
      C_E:     cond_eval = cc[CC_ZF];
      C_NE:    cond_eval = ~cc[CC_ZF];
      C_GE:    cond_eval = ~lt;
      C_G:     cond_eval = ~lt & ~cc[CC_ZF];
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86 ALU: result = aluB <fun> aluA, plus zero/sign/overflow flags.
module y86_alu
  import y86_pkg::*;
#(
  parameter int unsigned WORD_W = 64
) (
  input  logic [WORD_W-1:0] aluA,
  input  logic [WORD_W-1:0] aluB,
  input  alu_fun_e          fun,
  output logic [WORD_W-1:0] result,
  output logic              zf,
  output logic              sf,
  output logic              of
);

  localparam int unsigned MSB = WORD_W - 1;

  always_comb begin
    result = '0;
    of     = 1'b0;
    case (fun)
      ALU_ADD: begin
        result = aluB + aluA;
        of     = (aluA[MSB] == aluB[MSB]) & (result[MSB] != aluB[MSB]);
      end
      ALU_SUB: begin
        result = aluB - aluA;
        of     = (aluA[MSB] != aluB[MSB]) & (result[MSB] != aluB[MSB]);
      end
      ALU_AND: result = aluB & aluA;
      ALU_XOR: result = aluB ^ aluA;
      default: result = '0;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[MSB];

endmodule

// File: rtl/execute_stage_pipe.sv
// Pipelined Y86-64 execute stage: ALU, condition evaluation, CC register and
// a valid/ready E/M pipeline register with flush.
module execute_stage_pipe
  import y86_pkg::*;
#(
  parameter int unsigned WORD_W     = 64,
  parameter int unsigned REG_W      = 4,
  parameter int unsigned STACK_STEP = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [WORD_W-1:0] in_valA,
  input  logic [WORD_W-1:0] in_valB,
  input  logic [WORD_W-1:0] in_valC,
  input  logic [REG_W-1:0]  in_dstE,
  input  logic [REG_W-1:0]  in_dstM,
  input  logic              set_cc_en,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_icode,
  output logic [WORD_W-1:0] out_valE,
  output logic [WORD_W-1:0] out_valA,
  output logic [REG_W-1:0]  out_dstE,
  output logic [REG_W-1:0]  out_dstM,
  output logic              out_cnd,
  output logic              out_err,
  output logic [2:0]        cc
);

  localparam logic [REG_W-1:0]  L_RNONE = '1;
  localparam logic [WORD_W-1:0] L_STEP  = WORD_W'(STACK_STEP);
  localparam logic [3:0]        L_MAX_OPQ_FUN  = 4'd3;
  localparam logic [3:0]        L_MAX_COND_FUN = 4'd6;

  logic              r_out_valid;
  logic [3:0]        r_icode;
  logic [WORD_W-1:0] r_valE;
  logic [WORD_W-1:0] r_valA;
  logic [REG_W-1:0]  r_dstE;
  logic [REG_W-1:0]  r_dstM;
  logic              r_cnd;
  logic              r_err;
  logic [2:0]        r_cc;

  logic [WORD_W-1:0] w_alu_a;
  logic [WORD_W-1:0] w_alu_b;
  alu_fun_e          w_alu_fun;
  logic [WORD_W-1:0] w_alu_res;
  logic              w_zf;
  logic              w_sf;
  logic              w_of;
  logic              w_icode_bad;
  logic              w_opq_ok;
  logic              w_is_cond_op;
  logic              w_cond;
  logic              w_err;
  logic              w_cnd;
  logic [REG_W-1:0]  w_dstE;
  logic [WORD_W-1:0] w_valE;
  logic              w_accept;
  logic              w_hold;
  logic              w_cc_we;

  assign in_ready = ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready & ~flush;
  assign w_hold   = r_out_valid & ~out_ready;

  // Operand and function selection per icode; zero operands yield valE=0.
  always_comb begin
    w_alu_a     = '0;
    w_alu_b     = '0;
    w_alu_fun   = ALU_ADD;
    w_icode_bad = 1'b0;
    w_opq_ok    = 1'b0;
    case (in_icode)
      I_HALT, I_NOP, I_JXX: ;
      I_RRMOVQ: w_alu_a = in_valA;
      I_IRMOVQ: w_alu_a = in_valC;
      I_RMMOVQ, I_MRMOVQ: begin
        w_alu_a = in_valC;
        w_alu_b = in_valB;
      end
      I_OPQ: begin
        if (in_ifun <= L_MAX_OPQ_FUN) begin
          w_alu_a   = in_valA;
          w_alu_b   = in_valB;
          w_alu_fun = alu_fun_e'(in_ifun[1:0]);
          w_opq_ok  = 1'b1;
        end
      end
      I_CALL, I_PUSHQ: begin
        w_alu_a   = L_STEP;
        w_alu_b   = in_valB;
        w_alu_fun = ALU_SUB;
      end
      I_RET, I_POPQ: begin
        w_alu_a = L_STEP;
        w_alu_b = in_valB;
      end
      default: w_icode_bad = 1'b1;
    endcase
  end

  y86_alu #(
    .WORD_W (WORD_W)
  ) u_alu (
    .aluA   (w_alu_a),
    .aluB   (w_alu_b),
    .fun    (w_alu_fun),
    .result (w_alu_res),
    .zf     (w_zf),
    .sf     (w_sf),
    .of     (w_of)
  );

  // Condition sees the CC held before this instruction's own update.
  assign w_is_cond_op = (in_icode == I_RRMOVQ) | (in_icode == I_JXX);
  assign w_cond       = cond_eval(r_cc, in_ifun);
  assign w_cnd        = w_is_cond_op ? w_cond : 1'b1;
  assign w_dstE       = ((in_icode == I_RRMOVQ) & ~w_cond) ? L_RNONE : in_dstE;
  assign w_valE       = w_icode_bad ? '0 : w_alu_res;
  assign w_err        = w_icode_bad
                      | ((in_icode == I_OPQ) & ~w_opq_ok)
                      | (w_is_cond_op & (in_ifun > L_MAX_COND_FUN));
  assign w_cc_we      = w_accept & (in_icode == I_OPQ) & w_opq_ok & set_cc_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cc <= 3'b100;
    end else if (w_cc_we) begin
      r_cc[CC_ZF] <= w_zf;
      r_cc[CC_SF] <= w_sf;
      r_cc[CC_OF] <= w_of;
    end
  end

  // E/M register: flush kills, stall holds, otherwise load or drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_icode     <= '0;
      r_valE      <= '0;
      r_valA      <= '0;
      r_dstE      <= '0;
      r_dstM      <= '0;
      r_cnd       <= 1'b0;
      r_err       <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_icode     <= in_icode;
      r_valE      <= w_valE;
      r_valA      <= in_valA;
      r_dstE      <= w_dstE;
      r_dstM      <= in_dstM;
      r_cnd       <= w_cnd;
      r_err       <= w_err;
    end else if (~w_hold) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_icode = r_icode;
  assign out_valE  = r_valE;
  assign out_valA  = r_valA;
  assign out_dstE  = r_dstE;
  assign out_dstM  = r_dstM;
  assign out_cnd   = r_cnd;
  assign out_err   = r_err;
  assign cc        = r_cc;

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Bench for execute_stage_pipe: directed scenarios plus randomized traffic
// against a transaction-level model; a second 32-bit instance covers width.
module tb_execute_stage_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, set_cc_en, flush, out_valid, out_ready;
  logic [3:0]  in_icode, in_ifun, in_dstE, in_dstM, out_icode, out_dstE, out_dstM;
  logic [63:0] in_valA, in_valB, in_valC, out_valE, out_valA;
  logic        out_cnd, out_err;
  logic [2:0]  cc;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_cnd, s_out_err;
  logic [3:0]  s_in_icode, s_in_ifun, s_out_icode, s_out_dstE, s_out_dstM;
  logic [31:0] s_in_valA, s_in_valB, s_in_valC, s_out_valE, s_out_valA;
  logic [2:0]  s_cc;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the visible stage state.
  logic        m_valid;
  logic [3:0]  m_icode, m_dstE, m_dstM;
  logic [63:0] m_valE, m_valA;
  logic        m_cnd, m_err;
  logic [2:0]  m_cc;
  logic [63:0] held;

  always #5 clk = ~clk;

  execute_stage_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_icode(in_icode), .in_ifun(in_ifun), .in_valA(in_valA), .in_valB(in_valB),
    .in_valC(in_valC), .in_dstE(in_dstE), .in_dstM(in_dstM), .set_cc_en(set_cc_en),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_valE(out_valE), .out_valA(out_valA), .out_dstE(out_dstE), .out_dstM(out_dstM),
    .out_cnd(out_cnd), .out_err(out_err), .cc(cc)
  );

  execute_stage_pipe #(.WORD_W(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_icode(s_in_icode), .in_ifun(s_in_ifun), .in_valA(s_in_valA), .in_valB(s_in_valB),
    .in_valC(s_in_valC), .in_dstE(4'd5), .in_dstM(4'd6), .set_cc_en(1'b1),
    .flush(1'b0), .out_valid(s_out_valid), .out_ready(1'b1), .out_icode(s_out_icode),
    .out_valE(s_out_valE), .out_valA(s_out_valA), .out_dstE(s_out_dstE), .out_dstM(s_out_dstM),
    .out_cnd(s_out_cnd), .out_err(s_out_err), .cc(s_cc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result of one instruction from the ISA rules.
  task automatic exec_model(output logic [63:0] r, output logic cnd, output logic [3:0] dst,
                            output logic err, output logic cc_wr, output logic [2:0] cc_new);
    logic signed [64:0] wide;
    logic z, s, o, lt, cond;
    r = 64'd0; err = 1'b0; cc_wr = 1'b0; o = 1'b0; wide = '0;
    z = m_cc[2]; s = m_cc[1]; lt = m_cc[1] ^ m_cc[0];
    case (in_ifun)
      4'd0: cond = 1'b1;
      4'd1: cond = lt | z;
      4'd2: cond = lt;
      4'd3: cond = z;
      4'd4: cond = !z;
      4'd5: cond = !lt;
      4'd6: cond = !lt && !z;
      default: cond = 1'b0;
    endcase
    case (in_icode)
      4'd2: r = in_valA;
      4'd3: r = in_valC;
      4'd4, 4'd5: r = in_valC + in_valB;
      4'd6: begin
        cc_wr = 1'b1;
        case (in_ifun)
          4'd0: begin
            r = in_valB + in_valA;
            wide = $signed({in_valB[63], in_valB}) + $signed({in_valA[63], in_valA});
            o = wide[64] != wide[63];
          end
          4'd1: begin
            r = in_valB - in_valA;
            wide = $signed({in_valB[63], in_valB}) - $signed({in_valA[63], in_valA});
            o = wide[64] != wide[63];
          end
          4'd2: r = in_valB & in_valA;
          4'd3: r = in_valB ^ in_valA;
          default: begin err = 1'b1; cc_wr = 1'b0; end
        endcase
      end
      4'd8, 4'd10: r = in_valB - 64'd8;
      4'd9, 4'd11: r = in_valB + 64'd8;
      4'd0, 4'd1, 4'd7: r = 64'd0;
      default: err = 1'b1;
    endcase
    if ((in_icode == 4'd2 || in_icode == 4'd7) && in_ifun > 4'd6) err = 1'b1;
    cnd = (in_icode == 4'd2 || in_icode == 4'd7) ? cond : 1'b1;
    dst = (in_icode == 4'd2 && !cond) ? 4'hF : in_dstE;
    cc_wr = cc_wr & set_cc_en;
    cc_new = {r == 64'd0, r[63], o};
  endtask

  // One clock: check ready, advance the model, clock, compare outputs.
  task automatic tick;
    logic [63:0] r; logic cnd, err, cc_wr; logic [3:0] dst; logic [2:0] cc_new;
    logic acc, rdy;
    #1;
    rdy = !m_valid || out_ready;
    if (!reset) check("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    acc = in_valid && rdy && !flush;
    exec_model(r, cnd, dst, err, cc_wr, cc_new);
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_icode = 0; m_valE = 0; m_valA = 0; m_dstE = 0; m_dstM = 0;
      m_cnd = 0; m_err = 0; m_cc = 3'b100;
    end else if (flush) begin
      m_valid = 0;
    end else if (acc) begin
      m_valid = 1; m_icode = in_icode; m_valE = r; m_valA = in_valA; m_dstE = dst;
      m_dstM = in_dstM; m_cnd = cnd; m_err = err;
      if (cc_wr) m_cc = cc_new;
    end else if (!(m_valid && !out_ready)) begin
      m_valid = 0;
    end
    #1;
    check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    check("cc", {61'd0, cc}, {61'd0, m_cc});
    if (m_valid) begin
      check("out_icode", {60'd0, out_icode}, {60'd0, m_icode});
      check("out_valE", out_valE, m_valE);
      check("out_valA", out_valA, m_valA);
      check("out_dstE", {60'd0, out_dstE}, {60'd0, m_dstE});
      check("out_dstM", {60'd0, out_dstM}, {60'd0, m_dstM});
      check("out_cnd", {63'd0, out_cnd}, {63'd0, m_cnd});
      check("out_err", {63'd0, out_err}, {63'd0, m_err});
    end
  endtask

  task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] de);
    in_valid = 1; in_icode = ic; in_ifun = fn; in_valA = a; in_valB = b; in_valC = c;
    in_dstE = de; in_dstM = 4'd7; out_ready = 1; flush = 0; set_cc_en = 1;
    tick();
    in_valid = 0;
  endtask

  function automatic logic [63:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      4: return 64'($urandom_range(0, 16));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic tick32(input logic [3:0] ic, input logic [3:0] fn, input logic [31:0] a,
                        input logic [31:0] b);
    s_in_valid = 1; s_in_icode = ic; s_in_ifun = fn; s_in_valA = a; s_in_valB = b;
    s_in_valC = 32'd0;
    @(posedge clk); #1;
    s_in_valid = 0;
  endtask

  initial begin
    in_valid = 0; in_icode = 0; in_ifun = 0; in_valA = 0; in_valB = 0; in_valC = 0;
    in_dstE = 0; in_dstM = 0; set_cc_en = 1; flush = 0; out_ready = 1;
    s_in_valid = 0; s_in_icode = 0; s_in_ifun = 0; s_in_valA = 0; s_in_valB = 0; s_in_valC = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_cc", {61'd0, cc}, 64'd4);
    check("rst_valE", out_valE, 64'd0);
    check("rst_cnd_err", {62'd0, out_cnd, out_err}, 64'd0);
    tick();

    issue(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 4'd2);
    check("irmovq_valE", out_valE, 64'h1234);
    check("irmovq_cnd", {63'd0, out_cnd}, 64'd1);
    check("irmovq_cc", {61'd0, cc}, 64'd4);

    issue(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'd1);
    check("sub_valE", out_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_cc", {61'd0, cc}, 64'd2);
    issue(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 4'hF);
    check("jl_cnd", {63'd0, out_cnd}, 64'd1);

    issue(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'd1);
    check("addovf_valE", out_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("addovf_cc", {61'd0, cc}, 64'd3);
    // SF=OF=1, ZF=0: LE is false, so the move is squashed.
    issue(4'h2, 4'h1, 64'd9, 64'd0, 64'd0, 4'd3);
    check("cmovle_dstE", {60'd0, out_dstE}, 64'hF);
    issue(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'd1);
    check("add11_cc", {61'd0, cc}, 64'd0);
    issue(4'h2, 4'h3, 64'd9, 64'd0, 64'd0, 4'd3);
    check("cmove_dstE", {60'd0, out_dstE}, 64'hF);
    issue(4'h2, 4'h4, 64'd9, 64'd0, 64'd0, 4'd3);
    check("cmovne_dstE", {60'd0, out_dstE}, 64'd3);

    // Backpressure: hold three cycles, then release and accept once.
    issue(4'h3, 4'h0, 64'd0, 64'd0, 64'hAA, 4'd2);
    held = out_valE;
    in_valid = 1; in_icode = 4'h3; in_valC = 64'hBB; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_hold", out_valE, held);
    end
    out_ready = 1;
    tick();
    check("bp_release", out_valE, 64'hBB);
    in_valid = 0;
    tick();
    check("bp_once", {63'd0, out_valid}, 64'd0);

    // Flush while holding a valid OPq with another OPq incoming.
    issue(4'h6, 4'h1, 64'd1, 64'd1, 64'd0, 4'd1);
    held = {61'd0, cc};
    in_valid = 1; in_icode = 4'h6; in_ifun = 4'h1; in_valA = 64'd5; in_valB = 64'd3;
    out_ready = 0; flush = 1;
    tick();
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_cc", {61'd0, cc}, held);
    flush = 0; out_ready = 1; set_cc_en = 0;
    tick();
    check("nocc_cc", {61'd0, cc}, held);
    check("nocc_valE", out_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    in_valid = 0; set_cc_en = 1;

    issue(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'd4);
    check("push_valE", out_valE, 64'hF8);
    issue(4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 4'd4);
    check("pop_valE", out_valE, 64'h100);
    issue(4'hC, 4'h0, 64'd0, 64'd0, 64'd0, 4'd4);
    check("badicode_err", {63'd0, out_err}, 64'd1);
    issue(4'h6, 4'h5, 64'd1, 64'd2, 64'd0, 4'd1);
    check("badopq_err", {63'd0, out_err}, 64'd1);
    check("badopq_valE", out_valE, 64'd0);

    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 149) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = ($urandom_range(0, 9) < 8);
      set_cc_en = ($urandom_range(0, 7) != 0);
      in_icode  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15))
                                              : 4'($urandom_range(0, 11));
      in_ifun   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(0, 6));
      in_valA   = pick_val();
      in_valB   = pick_val();
      in_valC   = pick_val();
      in_dstE   = 4'($urandom_range(0, 15));
      in_dstM   = 4'($urandom_range(0, 15));
      tick();
    end
    reset = 0; in_valid = 0; flush = 0; out_ready = 1;
    tick();

    // 32-bit instance: SUB overflow at the most negative value.
    tick32(4'h6, 4'h1, 32'd1, 32'h8000_0000);
    check("w32_sub_valE", {32'd0, s_out_valE}, 64'h7FFF_FFFF);
    check("w32_sub_cc", {61'd0, s_cc}, 64'd1);
    tick32(4'h7, 4'h2, 32'd0, 32'd0);
    check("w32_jl_cnd", {63'd0, s_out_cnd}, 64'd1);
    tick32(4'hA, 4'h0, 32'd0, 32'h100);
    check("w32_push_valE", {32'd0, s_out_valE}, 64'hF8);
    check("w32_valid", {63'd0, s_out_valid}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
